vvtile_serial_feeder: RTL and testbench

// - Transmit end of the vvtile array's per-block serial-input interface: accepts RF_WIDTH-bit words, one per block, over valid/ready.
// - Shifts each block's word out bit-serially on serialOut[b], all blocks in lockstep, with per-block serialOut_valid.
// - Ping-pong double buffer: the next block-vector loads while the current one shifts. Sits between the host/DMA stream and the array's serialIn/serialIn_valid.

---
 rtl/vvfeed_pkg.sv | 36 +++
 rtl/vvfeed_bank.sv | 91 +++++++++
 rtl/vvtile_serial_feeder.sv | 169 ++++++++++++++++
 tb/tb_vvtile_serial_feeder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vvfeed_pkg.sv
// -----------------------------------------------------------------------------
// vvfeed_pkg
// Shared types and constants for the vvtile serial feeder.
//   bank_state_t   : life cycle of one ping-pong bank
//   BANK_A/BANK_B  : bank identifiers; banks are filled and shifted in the
//                    strict order A, B, A, ...
//   other_bank()   : the bank that follows a given bank in that order
//   bank_accepts() : bank can take another input beat
//   bank_pending() : bank holds a closed vector not yet fully shifted out
// -----------------------------------------------------------------------------
package vvfeed_pkg;

   typedef enum logic [1:0] {
      BANK_FREE,
      BANK_FILL,
      BANK_READY,
      BANK_SHIFT
   } bank_state_t;

   localparam logic BANK_A     = 1'b0;
   localparam logic BANK_B     = 1'b1;
   localparam logic FIRST_BANK = BANK_A;

   function automatic logic other_bank(input logic bank);
      return (bank == BANK_A) ? BANK_B : BANK_A;
   endfunction

   function automatic logic bank_accepts(input bank_state_t s);
      return (s == BANK_FREE) || (s == BANK_FILL);
   endfunction

   function automatic logic bank_pending(input bank_state_t s);
      return (s == BANK_READY) || (s == BANK_SHIFT);
   endfunction

endpackage

// File: rtl/vvfeed_bank.sv
// -----------------------------------------------------------------------------
// vvfeed_bank
// One ping-pong bank: BLOCK_COUNT words of RF_WIDTH bits plus a per-block
// written mask. Words are written one at a time through the load port and
// shifted out in parallel, one bit per lane per shift_en cycle.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears the mask)
//   load_en     : write load_word into block load_idx and set its mask bit
//   load_idx    : block index of the word being written
//   load_word   : word to store
//   shift_en    : advance every block word by one bit
//   clear       : drop the mask once the vector has been fully shifted
//   head_bits   : bit currently at the shift-out end of each block word
//   mask        : blocks written since the bank was last cleared
// -----------------------------------------------------------------------------
module vvfeed_bank
   import vvfeed_pkg::*;
#(
   parameter int RF_WIDTH    = 16,
   parameter int BLOCK_COUNT = 4,
   parameter int LSB_FIRST   = 1,
   parameter int IDX_W       = $clog2(BLOCK_COUNT) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_en,
   input  logic [IDX_W-1:0]       load_idx,
   input  logic [RF_WIDTH-1:0]    load_word,
   input  logic                   shift_en,
   input  logic                   clear,
   output logic [BLOCK_COUNT-1:0] head_bits,
   output logic [BLOCK_COUNT-1:0] mask
);

   logic [RF_WIDTH-1:0]    words_q [BLOCK_COUNT];
   logic [RF_WIDTH-1:0]    words_d [BLOCK_COUNT];
   logic [BLOCK_COUNT-1:0] mask_q;
   logic [BLOCK_COUNT-1:0] mask_d;

   always_comb begin
      // NOTE: every output of this block is given a default before any
      // condition, so no path leaves a signal unassigned and no latch appears.
      words_d = words_q;
      mask_d  = mask_q;
      if (shift_en) begin
         for (int b = 0; b < BLOCK_COUNT; b++) begin
            words_d[b] = (LSB_FIRST != 0) ? (words_q[b] >> 1) : (words_q[b] << 1);
         end
      end
      if (clear) begin
         mask_d = '0;
      end
      // Load and shift/clear never target the same bank in one cycle: a bank
      // is loaded only while FREE/FILL and shifted only while READY/SHIFT.
      if (load_en) begin
         for (int b = 0; b < BLOCK_COUNT; b++) begin
            if (load_idx == IDX_W'(b)) begin
               words_d[b] = load_word;
               mask_d[b]  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      head_bits = '0;
      for (int b = 0; b < BLOCK_COUNT; b++) begin
         head_bits[b] = (LSB_FIRST != 0) ? words_q[b][0] : words_q[b][RF_WIDTH-1];
      end
   end

   // NOTE: the word storage is deliberately not reset. Only the mask decides
   // what is visible downstream, so stale data in unwritten blocks is harmless
   // and the array stays a plain register file without a reset network.
   always_ff @(posedge clk) begin
      words_q <= words_d;
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples its pre-edge value regardless of block ordering.
      if (rst) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end

   assign mask = mask_q;

endmodule

// File: rtl/vvtile_serial_feeder.sv
// -----------------------------------------------------------------------------
// vvtile_serial_feeder
// Transmit end of the vvtile array's per-block serial input. Accepts one
// RF_WIDTH-bit word per block over valid/ready into a ping-pong pair of banks
// and shifts every block's word out bit-serially, all lanes in lockstep.
// While one bank shifts, the other fills.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   in_word          : word for the next block index
//   in_valid         : in_word/in_last valid
//   in_last          : closes the current vector early (qualified by in_valid)
//   in_ready         : feeder accepts a beat this cycle
//   serialOut        : serial bit per block lane (registered)
//   serialOut_valid  : per-lane valid, set only for blocks written in the
//                      vector being shifted (registered)
//   busy             : any bank not FREE
//   dbg_clk_enable   : debug stepper; with DEBUG=1 all state holds while low
// -----------------------------------------------------------------------------
module vvtile_serial_feeder
   import vvfeed_pkg::*;
#(
   parameter int DEBUG       = 1,
   parameter int RF_WIDTH    = 16,
   parameter int BLOCK_COUNT = 4,
   parameter int LSB_FIRST   = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [RF_WIDTH-1:0]    in_word,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [BLOCK_COUNT-1:0] serialOut,
   output logic [BLOCK_COUNT-1:0] serialOut_valid,
   output logic                   busy,
   input  logic                   dbg_clk_enable
);

   localparam int IDX_W = $clog2(BLOCK_COUNT) + 1;
   localparam int BIT_W = (RF_WIDTH > 1) ? $clog2(RF_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_COUNT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(RF_WIDTH - 1);

   // Registered state
   bank_state_t            state_q [2];
   bank_state_t            state_d [2];
   logic                   fill_ptr_q,  fill_ptr_d;
   logic                   shift_ptr_q, shift_ptr_d;
   logic [IDX_W-1:0]       wr_idx_q,    wr_idx_d;
   logic [BIT_W-1:0]       bit_cnt_q,   bit_cnt_d;
   logic [BLOCK_COUNT-1:0] serial_out_q,   serial_out_d;
   logic [BLOCK_COUNT-1:0] serial_valid_q, serial_valid_d;

   // Bank control and read-back
   logic [1:0]             load_en;
   logic [1:0]             shift_en;
   logic [1:0]             clear_en;
   logic [BLOCK_COUNT-1:0] head_bits [2];
   logic [BLOCK_COUNT-1:0] bank_mask [2];

   logic step_en;
   logic beat;
   logic closing;

   assign step_en = (DEBUG == 0) || dbg_clk_enable;

   // in_ready looks only at registered state, never at in_valid, so there is
   // no combinational path from the input handshake back to itself.
   assign in_ready = !rst && step_en && bank_accepts(state_q[fill_ptr_q]);
   assign beat     = in_valid && in_ready;
   assign closing  = (wr_idx_q == LAST_IDX) || in_last;
   assign busy     = (state_q[0] != BANK_FREE) || (state_q[1] != BANK_FREE);

   for (genvar g = 0; g < 2; g++) begin : g_bank
      vvfeed_bank #(
         .RF_WIDTH    (RF_WIDTH),
         .BLOCK_COUNT (BLOCK_COUNT),
         .LSB_FIRST   (LSB_FIRST),
         .IDX_W       (IDX_W)
      ) u_bank (
         .clk       (clk),
         .rst       (rst),
         .load_en   (load_en[g]),
         .load_idx  (wr_idx_q),
         .load_word (in_word),
         .shift_en  (shift_en[g]),
         .clear     (clear_en[g]),
         .head_bits (head_bits[g]),
         .mask      (bank_mask[g])
      );
   end

   always_comb begin
      state_d        = state_q;
      fill_ptr_d     = fill_ptr_q;
      shift_ptr_d    = shift_ptr_q;
      wr_idx_d       = wr_idx_q;
      bit_cnt_d      = bit_cnt_q;
      serial_out_d   = serial_out_q;
      serial_valid_d = serial_valid_q;
      load_en        = '0;
      shift_en       = '0;
      clear_en       = '0;

      if (step_en) begin
         // Shifter: shift_ptr always names the oldest bank, because fill and
         // shift both walk A,B,A,... A READY bank is picked up on the very
         // edge after it closes, and the bank after it follows with no bubble.
         if (bank_pending(state_q[shift_ptr_q])) begin
            serial_out_d            = head_bits[shift_ptr_q] & bank_mask[shift_ptr_q];
            serial_valid_d          = bank_mask[shift_ptr_q];
            shift_en[shift_ptr_q]   = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
               state_d[shift_ptr_q]  = BANK_FREE;
               clear_en[shift_ptr_q] = 1'b1;
               shift_ptr_d           = other_bank(shift_ptr_q);
               bit_cnt_d             = '0;
            end else begin
               state_d[shift_ptr_q]  = BANK_SHIFT;
               bit_cnt_d             = bit_cnt_q + 1'b1;
            end
         end else begin
            serial_out_d   = '0;
            serial_valid_d = '0;
         end

         // Fill side: the fill bank is FREE/FILL whenever a beat is accepted,
         // so it never collides with the bank the shifter is touching.
         if (beat) begin
            load_en[fill_ptr_q] = 1'b1;
            if (closing) begin
               state_d[fill_ptr_q] = BANK_READY;
               wr_idx_d            = '0;
               fill_ptr_d          = other_bank(fill_ptr_q);
            end else begin
               state_d[fill_ptr_q] = BANK_FILL;
               wr_idx_d            = wr_idx_q + 1'b1;
            end
         end
      end
   end

   // Reset takes priority over the debug stepper so an abort is always
   // immediate.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q[0]     <= BANK_FREE;
         state_q[1]     <= BANK_FREE;
         fill_ptr_q     <= FIRST_BANK;
         shift_ptr_q    <= FIRST_BANK;
         wr_idx_q       <= '0;
         bit_cnt_q      <= '0;
         serial_out_q   <= '0;
         serial_valid_q <= '0;
      end else begin
         state_q        <= state_d;
         fill_ptr_q     <= fill_ptr_d;
         shift_ptr_q    <= shift_ptr_d;
         wr_idx_q       <= wr_idx_d;
         bit_cnt_q      <= bit_cnt_d;
         serial_out_q   <= serial_out_d;
         serial_valid_q <= serial_valid_d;
      end
   end

   assign serialOut       = serial_out_q;
   assign serialOut_valid = serial_valid_q;

endmodule

// File: tb/tb_vvtile_serial_feeder.sv
module tb_vvtile_serial_feeder;

   localparam int RF_WIDTH    = 16;
   localparam int BLOCK_COUNT = 4;

   typedef struct packed {
      logic [BLOCK_COUNT-1:0][RF_WIDTH-1:0] words;
      logic [BLOCK_COUNT-1:0]               mask;
   } vec_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [RF_WIDTH-1:0]    in_word = '0;
   logic                   in_valid = 1'b0;
   logic                   in_last = 1'b0;
   logic                   in_ready;
   logic [BLOCK_COUNT-1:0] serialOut;
   logic [BLOCK_COUNT-1:0] serialOut_valid;
   logic                   busy;
   logic                   dbg_clk_enable = 1'b1;

   vvtile_serial_feeder #(
      .DEBUG       (1),
      .RF_WIDTH    (RF_WIDTH),
      .BLOCK_COUNT (BLOCK_COUNT),
      .LSB_FIRST   (1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_word         (in_word),
      .in_valid        (in_valid),
      .in_last         (in_last),
      .in_ready        (in_ready),
      .serialOut       (serialOut),
      .serialOut_valid (serialOut_valid),
      .busy            (busy),
      .dbg_clk_enable  (dbg_clk_enable)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic en_at_edge = 1'b1;
   logic dbg_mode = 1'b0;
   int   dbg_checks = 0;
   int   beats = 0;
   int   stall_cycles = 0;
   int   vectors_seen = 0;

   vec_t exp_q[$];
   int   start_q[$];
   vec_t build = '0;
   int   build_n = 0;

   // Monitor state
   logic                                 active = 1'b0;
   int                                   bit_pos = 0;
   vec_t                                 cur;
   logic [BLOCK_COUNT-1:0][RF_WIDTH-1:0] got_w;

   localparam logic [15:0] PP_WORDS [12] = '{
      16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
      16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978,
      16'hC001, 16'h0C0D, 16'hBEEF, 16'h7E57
   };
   localparam logic [15:0] BP_WORDS [8] = '{
      16'hA5A5, 16'h5A5A, 16'h3333,
      16'hCAFE,
      16'h0102, 16'h0304, 16'h0506, 16'h0708
   };
   localparam logic BP_LAST [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      en_at_edge <= dbg_clk_enable;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp_v, cyc);
      end
   endtask

   // One beat: hold in_valid until in_ready, then let one edge consume it.
   // The expected vector is queued the moment the closing beat is accepted.
   task automatic send(input logic [15:0] w, input logic last);
      int guard = 0;
      in_word  = w;
      in_last  = last;
      in_valid = 1'b1;
      #1;
      while (!in_ready && guard < 300) begin
         stall_cycles++;
         guard++;
         @(posedge clk);
         #2;
      end
      if (!in_ready) begin
         check("send_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clk);
         #1;
         beats++;
         build.words[build_n] = w;
         build.mask[build_n]  = 1'b1;
         build_n++;
         if (last || build_n == BLOCK_COUNT) begin
            exp_q.push_back(build);
            build   = '0;
            build_n = 0;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int   guard = 0;
      logic pending;
      pending = busy || active || (exp_q.size() != 0);
      while (pending && guard < 1000) begin
         @(posedge clk);
         #3;
         guard++;
         pending = busy || active || (exp_q.size() != 0);
      end
      check(name, {31'd0, pending}, 32'd0);
   endtask

   // Debug stepper: enable every third cycle while dbg_mode is set.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (dbg_mode) begin
            dbg_clk_enable = (cyc % 3 == 0);
            if (!dbg_clk_enable && dbg_checks < 8) begin
               #1;
               check("in_ready_while_disabled", {31'd0, in_ready}, 32'd0);
               dbg_checks++;
            end
         end else begin
            dbg_clk_enable = 1'b1;
         end
      end
   end

   // Monitor: samples only after edges on which the DUT was enabled, pops the
   // oldest expected vector when a new one begins, and compares lane words.
   always @(negedge clk) begin
      if (rst) begin
         active  = 1'b0;
         bit_pos = 0;
      end else if (en_at_edge) begin
         if (!active) begin
            if (serialOut_valid != '0) begin
               active  = 1'b1;
               bit_pos = 0;
               got_w   = '0;
               start_q.push_back(cyc);
               if (exp_q.size() == 0) begin
                  check("unexpected_vector", {28'd0, serialOut_valid}, 32'd0);
                  cur      = '0;
                  cur.mask = serialOut_valid;
               end else begin
                  cur = exp_q.pop_front();
               end
            end else begin
               check("idle_serialOut", {28'd0, serialOut}, 32'd0);
            end
         end
         if (active) begin
            check("valid_mask", {28'd0, serialOut_valid}, {28'd0, cur.mask});
            for (int b = 0; b < BLOCK_COUNT; b++) begin
               got_w[b][bit_pos] = serialOut[b];
            end
            bit_pos++;
            if (bit_pos == RF_WIDTH) begin
               for (int b = 0; b < BLOCK_COUNT; b++) begin
                  check($sformatf("lane%0d_word", b), {16'd0, got_w[b]}, {16'd0, cur.words[b]});
               end
               active  = 1'b0;
               bit_pos = 0;
               vectors_seen++;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int close_cyc;
      int base;
      int beats0;
      int stall0;
      int seen0;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      check("rst_serialOut", {28'd0, serialOut}, 32'd0);
      check("rst_valid", {28'd0, serialOut_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

      // Full vector, latency and exact 16-cycle valid window
      send(16'h0001, 1'b0);
      send(16'h8000, 1'b0);
      send(16'hAAAA, 1'b0);
      send(16'hFFFF, 1'b0);
      close_cyc = cyc;
      repeat (17) @(posedge clk);
      #3;
      check("full_valid_dropped", {28'd0, serialOut_valid}, 32'd0);
      check("full_busy_clear", {31'd0, busy}, 32'd0);
      check("full_latency", start_q[start_q.size()-1], close_cyc + 1);
      check("full_vectors", vectors_seen, 1);

      // Partial vector closed by in_last
      send(16'h00FF, 1'b0);
      send(16'h0F0F, 1'b1);
      wait_idle("partial_idle");
      check("partial_vectors", vectors_seen, 2);

      // Ping-pong: 12 full-rate beats
      base   = start_q.size();
      beats0 = beats;
      stall0 = stall_cycles;
      for (int i = 0; i < 12; i++) begin
         send(PP_WORDS[i], 1'b0);
      end
      wait_idle("pingpong_idle");
      check("pingpong_beats", beats - beats0, 12);
      check("pingpong_stalled", {31'd0, (stall_cycles - stall0) > 0}, 32'd1);
      check("pingpong_gap_1_2", start_q[base+1] - start_q[base], RF_WIDTH);
      check("pingpong_gap_2_3", start_q[base+2] - start_q[base+1], RF_WIDTH);

      // Backpressure with early, single-beat and redundant in_last closes
      seen0  = vectors_seen;
      beats0 = beats;
      for (int i = 0; i < 8; i++) begin
         send(BP_WORDS[i], BP_LAST[i]);
      end
      wait_idle("backpressure_idle");
      check("backpressure_vectors", vectors_seen - seen0, 3);
      check("backpressure_beats", beats - beats0, 8);

      // Reset at bit 7 of a vector while the other bank is READY
      send(16'h1111, 1'b0);
      send(16'h2222, 1'b0);
      send(16'h4444, 1'b0);
      send(16'h8888, 1'b0);
      close_cyc = cyc;
      send(16'hDEAD, 1'b0);
      send(16'hBEEF, 1'b0);
      send(16'hF00D, 1'b0);
      send(16'hFACE, 1'b0);
      while (cyc < close_cyc + 8) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #3;
      check("midrst_valid", {28'd0, serialOut_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      exp_q.delete();
      build   = '0;
      build_n = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_ready_after", {31'd0, in_ready}, 32'd1);
      seen0 = vectors_seen;
      send(16'h0123, 1'b0);
      send(16'h4567, 1'b0);
      send(16'h89AB, 1'b0);
      send(16'hCDEF, 1'b0);
      close_cyc = cyc;
      wait_idle("midrst_clean_idle");
      check("midrst_clean_latency", start_q[start_q.size()-1], close_cyc + 1);
      check("midrst_clean_vectors", vectors_seen - seen0, 1);

      // Debug stepping: same vector as the full-vector test, one bit per step
      seen0    = vectors_seen;
      @(posedge clk);
      #3;
      dbg_mode = 1'b1;
      send(16'h0001, 1'b0);
      send(16'h8000, 1'b0);
      send(16'hAAAA, 1'b0);
      send(16'hFFFF, 1'b0);
      wait_idle("debug_idle");
      dbg_mode = 1'b0;
      check("debug_vectors", vectors_seen - seen0, 1);
      check("debug_ready_checks", {31'd0, dbg_checks > 0}, 32'd1);

      repeat (3) @(posedge clk);
      #3;
      check("final_queue_empty", exp_q.size(), 0);
      check("final_vectors", vectors_seen, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
